// File: rtl/wakeup_scoreboard_n.sv
// Physical-register wakeup scoreboard: per-preg ready flag and latency countdown,
// N-wide dispatch with intra-group forwarding, N broadcast ports and mask recovery.
module wakeup_scoreboard_n #(
   parameter int PREG_NUM = 64,
   parameter int PREG_SEL = 6,
   parameter int DISP_W   = 2,
   parameter int BC_W     = 2,
   parameter int LAT_W    = 3,
   parameter int TYPE_W   = 2,
   parameter int LAT_ALU  = 1,
   parameter int LAT_BR   = 1,
   parameter int LAT_MUL  = 3,
   parameter int LAT_LDST = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DISP_W-1:0]            disp_valid,
   input  logic [DISP_W-1:0]            disp_wr,
   input  logic [DISP_W*PREG_SEL-1:0]   disp_dst,
   input  logic [DISP_W*TYPE_W-1:0]     disp_type,
   input  logic [2*DISP_W*PREG_SEL-1:0] src_tag,
   output logic [2*DISP_W-1:0]          src_ready,
   output logic [2*DISP_W-1:0]          src_issued,
   output logic [2*DISP_W*LAT_W-1:0]    src_wait,
   input  logic [BC_W-1:0]              bc_valid,
   input  logic [BC_W*PREG_SEL-1:0]     bc_tag,
   input  logic                         rec_valid,
   input  logic [PREG_NUM-1:0]          rec_mask
);

   function automatic logic [LAT_W-1:0] type_lat(input logic [TYPE_W-1:0] t);
      logic [LAT_W-1:0] l;
      if (t == TYPE_W'(1))      l = LAT_W'(LAT_BR);
      else if (t == TYPE_W'(2)) l = LAT_W'(LAT_MUL);
      else if (t == TYPE_W'(3)) l = LAT_W'(LAT_LDST);
      else                      l = LAT_W'(LAT_ALU);
      return l;
   endfunction

   logic [PREG_NUM-1:0] ready_q;
   logic [PREG_NUM-1:0] run_q;
   logic [LAT_W-1:0]    cnt_q [PREG_NUM];
   logic [LAT_W-1:0]    lat_q [PREG_NUM];

   logic [PREG_NUM-1:0] disp_hit;
   logic [PREG_NUM-1:0] bc_hit;
   logic [LAT_W-1:0]    disp_lat [PREG_NUM];

   always_comb begin
      disp_hit = '0;
      bc_hit   = '0;
      for (int p = 0; p < PREG_NUM; p++) begin
         disp_lat[p] = '0;
         for (int i = 0; i < DISP_W; i++) begin
            if (disp_valid[i] && disp_wr[i] &&
                disp_dst[i*PREG_SEL +: PREG_SEL] == PREG_SEL'(p)) begin
               disp_hit[p] = 1'b1;
               disp_lat[p] = type_lat(disp_type[i*TYPE_W +: TYPE_W]);
            end
         end
         for (int j = 0; j < BC_W; j++) begin
            if (bc_valid[j] && bc_tag[j*PREG_SEL +: PREG_SEL] == PREG_SEL'(p))
               bc_hit[p] = 1'b1;
         end
      end
   end

   // Priority per preg: recovery, then dispatch, then broadcast, then countdown.
   // Broadcast only acts on an idle, not-ready preg, so it never collides with countdown.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < PREG_NUM; p++) begin
            ready_q[p] <= 1'b1;
            run_q[p]   <= 1'b0;
            cnt_q[p]   <= '0;
            lat_q[p]   <= '0;
         end
      end else begin
         for (int p = 0; p < PREG_NUM; p++) begin
            if (rec_valid && rec_mask[p]) begin
               ready_q[p] <= 1'b1;
               run_q[p]   <= 1'b0;
               cnt_q[p]   <= '0;
            end else if (disp_hit[p]) begin
               ready_q[p] <= 1'b0;
               run_q[p]   <= 1'b0;
               cnt_q[p]   <= '0;
               lat_q[p]   <= disp_lat[p];
            end else if (bc_hit[p] && !ready_q[p] && !run_q[p]) begin
               if (lat_q[p] <= LAT_W'(1)) begin
                  ready_q[p] <= 1'b1;
               end else begin
                  run_q[p] <= 1'b1;
                  cnt_q[p] <= lat_q[p] - LAT_W'(1);
               end
            end else if (run_q[p]) begin
               if (cnt_q[p] <= LAT_W'(1)) begin
                  ready_q[p] <= 1'b1;
                  run_q[p]   <= 1'b0;
                  cnt_q[p]   <= '0;
               end else begin
                  cnt_q[p] <= cnt_q[p] - LAT_W'(1);
               end
            end
         end
      end
   end

   // A younger slot reading an older slot's fresh dst sees the producer's full latency.
   always_comb begin
      src_ready  = '0;
      src_issued = '0;
      src_wait   = '0;
      for (int s = 0; s < 2*DISP_W; s++) begin
         logic [PREG_SEL-1:0] tag;
         logic                rdy;
         logic                iss;
         logic [LAT_W-1:0]    wt;
         tag = src_tag[s*PREG_SEL +: PREG_SEL];
         if (ready_q[tag]) begin
            rdy = 1'b1;
            iss = 1'b0;
            wt  = '0;
         end else if (run_q[tag]) begin
            rdy = 1'b0;
            iss = 1'b1;
            wt  = cnt_q[tag];
         end else begin
            rdy = 1'b0;
            iss = 1'b0;
            wt  = lat_q[tag];
         end
         for (int m = 0; m < s/2; m++) begin
            if (disp_valid[m] && disp_wr[m] && disp_dst[m*PREG_SEL +: PREG_SEL] == tag) begin
               rdy = 1'b0;
               iss = 1'b0;
               wt  = type_lat(disp_type[m*TYPE_W +: TYPE_W]);
            end
         end
         src_ready[s]             = rdy;
         src_issued[s]            = iss;
         src_wait[s*LAT_W +: LAT_W] = wt;
      end
   end

   logic dup_dst;
   logic dup_bc;

   always_comb begin
      dup_dst = 1'b0;
      dup_bc  = 1'b0;
      for (int a = 0; a < DISP_W; a++) begin
         for (int b = a + 1; b < DISP_W; b++) begin
            if (disp_valid[a] && disp_wr[a] && disp_valid[b] && disp_wr[b] &&
                disp_dst[a*PREG_SEL +: PREG_SEL] == disp_dst[b*PREG_SEL +: PREG_SEL])
               dup_dst = 1'b1;
         end
      end
      for (int a = 0; a < BC_W; a++) begin
         for (int b = a + 1; b < BC_W; b++) begin
            if (bc_valid[a] && bc_valid[b] &&
                bc_tag[a*PREG_SEL +: PREG_SEL] == bc_tag[b*PREG_SEL +: PREG_SEL])
               dup_bc = 1'b1;
         end
      end
   end

   a_no_dup_dst: assert property (@(posedge clk) disable iff (reset) !dup_dst);
   a_no_dup_bc:  assert property (@(posedge clk) disable iff (reset) !dup_bc);

endmodule

// File: tb/tb_wakeup_scoreboard_n.sv
// Directed bench for wakeup_scoreboard_n with hand-computed expectations.
module tb_wakeup_scoreboard_n;

   localparam int PNUM = 64;
   localparam int PSEL = 6;
   localparam int DW   = 2;
   localparam int BW   = 2;
   localparam int LW   = 3;
   localparam int TW   = 2;

   logic                 clk;
   logic                 reset;
   logic [DW-1:0]        disp_valid;
   logic [DW-1:0]        disp_wr;
   logic [DW*PSEL-1:0]   disp_dst;
   logic [DW*TW-1:0]     disp_type;
   logic [2*DW*PSEL-1:0] src_tag;
   logic [2*DW-1:0]      src_ready;
   logic [2*DW-1:0]      src_issued;
   logic [2*DW*LW-1:0]   src_wait;
   logic [BW-1:0]        bc_valid;
   logic [BW*PSEL-1:0]   bc_tag;
   logic                 rec_valid;
   logic [PNUM-1:0]      rec_mask;

   int checks   = 0;
   int failures = 0;

   wakeup_scoreboard_n dut (
      .clk        (clk),
      .reset      (reset),
      .disp_valid (disp_valid),
      .disp_wr    (disp_wr),
      .disp_dst   (disp_dst),
      .disp_type  (disp_type),
      .src_tag    (src_tag),
      .src_ready  (src_ready),
      .src_issued (src_issued),
      .src_wait   (src_wait),
      .bc_valid   (bc_valid),
      .bc_tag     (bc_tag),
      .rec_valid  (rec_valid),
      .rec_mask   (rec_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkSrc(input string tag, input int s, input int r, input int iss, input int w);
      checkOutput({tag, "_ready"},  32'(src_ready[s]),  32'(r));
      checkOutput({tag, "_issued"}, 32'(src_issued[s]), 32'(iss));
      checkOutput({tag, "_wait"},   32'(src_wait[s*LW +: LW]), 32'(w));
   endtask

   task automatic clearInputs();
      disp_valid = '0;
      disp_wr    = '0;
      disp_dst   = '0;
      disp_type  = '0;
      src_tag    = '0;
      bc_valid   = '0;
      bc_tag     = '0;
      rec_valid  = 1'b0;
      rec_mask   = '0;
   endtask

   task automatic dispatch(input int slot, input int dst, input int typ);
      disp_valid[slot]              = 1'b1;
      disp_wr[slot]                 = 1'b1;
      disp_dst[slot*PSEL +: PSEL]   = PSEL'(dst);
      disp_type[slot*TW +: TW]      = TW'(typ);
   endtask

   task automatic bcast(input int port, input int tag);
      bc_valid[port]            = 1'b1;
      bc_tag[port*PSEL +: PSEL] = PSEL'(tag);
   endtask

   task automatic setSrc(input int s, input int tag);
      src_tag[s*PSEL +: PSEL] = PSEL'(tag);
   endtask

   // One clock: inputs held through the edge, then returned to idle just after it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      clearInputs();
   endtask

   initial begin
      reset = 1'b1;
      clearInputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state for every tag
      for (int b = 0; b < PNUM/4; b++) begin
         for (int k = 0; k < 4; k++) setSrc(k, 4*b + k);
         #1;
         checkOutput("reset_ready",  32'(src_ready),  32'hF);
         checkOutput("reset_issued", 32'(src_issued), 32'h0);
         checkOutput("reset_wait",   32'(src_wait),   32'h0);
      end
      @(posedge clk);
      #1;

      // MUL p5: dispatched at T, broadcast at T+2
      dispatch(0, 5, 2);
      applyStimulus();
      setSrc(0, 5); #1; checkSrc("mul_t1", 0, 0, 0, 3);
      applyStimulus();
      bcast(0, 5); setSrc(0, 5); #1; checkSrc("mul_t2", 0, 0, 0, 3);
      applyStimulus();
      setSrc(0, 5); #1; checkSrc("mul_t3", 0, 0, 1, 2);
      applyStimulus();
      setSrc(0, 5); #1; checkSrc("mul_t4", 0, 0, 1, 1);
      applyStimulus();
      setSrc(0, 5); #1; checkSrc("mul_t5", 0, 1, 0, 0);
      applyStimulus();

      // ALU p7: single-cycle wakeup, repeated broadcast ignored
      dispatch(0, 7, 0);
      applyStimulus();
      bcast(1, 7); setSrc(1, 7); #1; checkSrc("alu_t1", 1, 0, 0, 1);
      applyStimulus();
      setSrc(1, 7); #1; checkSrc("alu_t2", 1, 1, 0, 0);
      applyStimulus();
      bcast(0, 7); setSrc(1, 7); #1; checkSrc("alu_t3", 1, 1, 0, 0);
      applyStimulus();
      setSrc(1, 7); #1; checkSrc("alu_t4", 1, 1, 0, 0);
      applyStimulus();

      // Intra-group forwarding of LDST p9; slot0 still sees registered state
      dispatch(0, 9, 3);
      setSrc(0, 9); setSrc(2, 9); setSrc(3, 9);
      #1;
      checkSrc("fwd_slot0", 0, 1, 0, 0);
      checkSrc("fwd_slot1a", 2, 0, 0, 4);
      checkSrc("fwd_slot1b", 3, 0, 0, 4);
      applyStimulus();
      setSrc(0, 9); #1; checkSrc("fwd_after", 0, 0, 0, 4);
      // No forwarding when the older slot does not write
      disp_valid[0] = 1'b1; disp_dst[0 +: PSEL] = PSEL'(10); disp_type[0 +: TW] = TW'(3);
      setSrc(2, 10); #1; checkSrc("fwd_nowr", 2, 1, 0, 0);
      applyStimulus();

      // Recovery of counting p3; p4 keeps counting; masked dispatch of p20 overridden
      dispatch(0, 3, 3); dispatch(1, 4, 3);
      applyStimulus();
      bcast(0, 3); bcast(1, 4);
      applyStimulus();
      setSrc(0, 3); setSrc(1, 4); #1;
      checkSrc("rec_pre_p3", 0, 0, 1, 3);
      checkSrc("rec_pre_p4", 1, 0, 1, 3);
      dispatch(0, 20, 0);
      rec_valid = 1'b1;
      rec_mask  = (64'd1 << 3) | (64'd1 << 20);
      applyStimulus();
      setSrc(0, 3); setSrc(1, 4); setSrc(2, 20); #1;
      checkSrc("rec_p3", 0, 1, 0, 0);
      checkSrc("rec_p4", 1, 0, 1, 2);
      checkSrc("rec_p20", 2, 1, 0, 0);
      applyStimulus();

      // Dual broadcast p12 (ALU) and p13 (MUL), then reset mid-countdown
      dispatch(0, 12, 0); dispatch(1, 13, 2);
      applyStimulus();
      bcast(0, 12); bcast(1, 13);
      setSrc(0, 12); setSrc(1, 13); #1;
      checkSrc("dual_t0_p12", 0, 0, 0, 1);
      checkSrc("dual_t0_p13", 1, 0, 0, 3);
      applyStimulus();
      setSrc(0, 12); setSrc(1, 13); setSrc(2, 9); #1;
      checkSrc("dual_t1_p12", 0, 1, 0, 0);
      checkSrc("dual_t1_p13", 1, 0, 1, 2);
      checkSrc("dual_t1_p9",  2, 0, 0, 4);
      reset = 1'b1;
      applyStimulus();
      reset = 1'b0;
      setSrc(1, 13); setSrc(2, 9); #1;
      checkSrc("rst_p13", 1, 1, 0, 0);
      checkSrc("rst_p9",  2, 1, 0, 0);
      applyStimulus();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
